// File: rtl/serializer_x000.sv
// Parallel-to-serial feeder for the "000" detector: a small word FIFO drains into a
// bit shifter that drives x one bit per clock and holds IDLE_BIT when nothing is pending.
module serializer_x000 #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int MSB_FIRST = 1,
    parameter int IDLE_BIT  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     load,
    output logic                     ready,
    output logic                     x,
    output logic                     x_valid,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             x_q, x_d;
    logic             x_valid_q, x_valid_d;
    logic             busy_q, busy_d;
    logic             push, pop;

    assign ready   = (count_q < DEPTH_C);
    assign count   = count_q;
    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign busy    = busy_q;

    always_comb begin
        push      = load && ready;
        // Pop uses the registered count, so a word written this edge is never bypassed.
        pop       = (count_q != '0) && ((state_q == S_IDLE) || (idx_q == LAST_IDX));
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        state_d   = state_q;
        sreg_d    = sreg_q;
        idx_d     = idx_q;
        x_d       = 1'(IDLE_BIT);
        x_valid_d = 1'b0;
        busy_d    = 1'b0;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    sreg_d  = mem_q[rd_ptr_q];
                    idx_d   = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (idx_q == LAST_IDX) begin
                    idx_d = '0;
                    if (pop) begin
                        sreg_d = mem_q[rd_ptr_q];
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered: derive them from the state being entered.
        if (state_d == S_SHIFT) begin
            x_valid_d = 1'b1;
            busy_d    = 1'b1;
            x_d       = (MSB_FIRST != 0) ? sreg_d[LAST_IDX - idx_d] : sreg_d[idx_d];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= S_IDLE;
            sreg_q    <= '0;
            idx_q     <= '0;
            x_q       <= 1'(IDLE_BIT);
            x_valid_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            idx_q     <= idx_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            busy_q    <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule

// File: tb/tb_serializer_x000.sv
// Scoreboard bench for serializer_x000: drivers queue expected serial bits, negedge
// monitors pop and compare whenever x_valid is high.
module tb_serializer_x000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_in = '0;
    logic       load = 1'b0;
    logic       ready, x, x_valid, busy;
    logic [2:0] count;

    logic [7:0] l_data_in = '0;
    logic       l_load = 1'b0;
    logic       l_ready, l_x, l_x_valid, l_busy;
    logic [2:0] l_count;

    int checks = 0;
    int failures = 0;
    bit q[$];
    bit lq[$];
    int valid_cycles = 0;
    int runs = 0;
    logic prev_valid = 1'b0;

    serializer_x000 #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1), .IDLE_BIT(1)) u_msb (
        .clk(clk), .reset(reset), .data_in(data_in), .load(load), .ready(ready),
        .x(x), .x_valid(x_valid), .busy(busy), .count(count)
    );

    serializer_x000 #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(0), .IDLE_BIT(1)) u_lsb (
        .clk(clk), .reset(reset), .data_in(l_data_in), .load(l_load), .ready(l_ready),
        .x(l_x), .x_valid(l_x_valid), .busy(l_busy), .count(l_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (x_valid) begin
                valid_cycles++;
                if (!prev_valid) runs++;
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL mon_unexpected_bit actual=%0d required=none", x);
                end else begin
                    check("mon_x", int'(x), int'(q.pop_front()));
                end
            end else begin
                check("mon_idle_x", int'(x), 1);
            end
            check("mon_busy", int'(busy), int'(x_valid));
        end
        prev_valid = reset ? x_valid : 1'b0;
    end

    always @(negedge clk) begin
        if (reset) begin
            if (l_x_valid) begin
                if (lq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL lsb_unexpected_bit actual=%0d required=none", l_x);
                end else begin
                    check("lsb_x", int'(l_x), int'(lq.pop_front()));
                end
            end else begin
                check("lsb_idle_x", int'(l_x), 1);
            end
        end
    end

    // Drives one word for the next edge; load is left high so calls can run back to back.
    task automatic issue(input logic [7:0] w, input bit accept);
        data_in = w;
        load    = 1'b1;
        if (accept) begin
            for (int i = 7; i >= 0; i--) q.push_back(w[i]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name, input int bound);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(!x_valid && !l_x_valid && q.size() == 0 && lq.size() == 0) && t < bound);
        if (x_valid || l_x_valid || q.size() != 0 || lq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=%0d_bits_left required=0", name, q.size() + lq.size());
        end
        check({name, "_count"}, int'(count), 0);
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_ready"}, int'(ready), 1);
        check({name, "_lcount"}, int'(l_count), 0);
    endtask

    logic [7:0] words [10] = '{8'h3C, 8'hA5, 8'h5A, 8'hC3, 8'h96, 8'h69, 8'hF0, 8'h0F, 8'h81, 8'h7E};

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_x", int'(x), 1);
        check("rst_x_valid", int'(x_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_count", int'(count), 0);
        check("rst_ready", int'(ready), 1);
        reset = 1'b1;
        @(negedge clk);

        // Test 1: single word, first bit one cycle after the push edge
        valid_cycles = 0; runs = 0;
        issue(8'h0F, 1'b1);
        load = 1'b0;
        @(negedge clk);
        check("t1_lat_idle", int'(x_valid), 0);
        @(negedge clk);
        check("t1_lat_first", int'(x_valid), 1);
        wait_idle("t1", 100);
        check("t1_bits", valid_cycles, 8);
        check("t1_runs", runs, 1);

        // Test 2: back-to-back words with no gap
        valid_cycles = 0; runs = 0;
        issue(8'h80, 1'b1);
        issue(8'h01, 1'b1);
        load = 1'b0;
        wait_idle("t2", 100);
        check("t2_bits", valid_cycles, 16);
        check("t2_runs", runs, 1);

        // Test 3: overfill, sixth word refused
        valid_cycles = 0; runs = 0;
        issue(8'hA1, 1'b1);
        issue(8'hB2, 1'b1);
        issue(8'hC3, 1'b1);
        issue(8'hD4, 1'b1);
        issue(8'hE5, 1'b1);
        check("t3_full_count", int'(count), 4);
        check("t3_full_ready", int'(ready), 0);
        issue(8'hF6, 1'b0);
        load = 1'b0;
        check("t3_refused_count", int'(count), 4);
        wait_idle("t3", 200);
        check("t3_bits", valid_cycles, 40);
        check("t3_runs", runs, 1);

        // Test 4: asynchronous reset mid-word
        valid_cycles = 0; runs = 0;
        issue(8'hAA, 1'b1);
        load = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("t4_x", int'(x), 1);
        check("t4_x_valid", int'(x_valid), 0);
        check("t4_busy", int'(busy), 0);
        check("t4_count", int'(count), 0);
        check("t4_ready", int'(ready), 1);
        q.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (12) @(negedge clk);
        check("t4_bits", valid_cycles, 3);
        check("t4_post_x_valid", int'(x_valid), 0);

        // Test 5: ten words paced on ready, pointers wrap twice
        valid_cycles = 0; runs = 0;
        for (int i = 0; i < 10; i++) begin
            int t = 0;
            while (!ready && t < 100) begin
                load = 1'b0;
                @(posedge clk);
                #1;
                t++;
            end
            check("t5_ready_wait", int'(ready), 1);
            issue(words[i], 1'b1);
        end
        load = 1'b0;
        wait_idle("t5", 300);
        check("t5_bits", valid_cycles, 80);
        check("t5_runs", runs, 1);

        // Test 6: LSB-first instance, 8'h01 -> 1 then seven 0s
        l_data_in = 8'h01;
        l_load = 1'b1;
        lq.push_back(1'b1);
        for (int i = 0; i < 7; i++) lq.push_back(1'b0);
        @(posedge clk);
        #1;
        l_load = 1'b0;
        wait_idle("t6", 100);
        check("t6_lbusy", int'(l_busy), 0);
        check("t6_lx", int'(l_x), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serializer_x000.md
Name: serializer_x000

Overview:
- Upstream feeder for the serial "000" pattern-detector FSM.
- Accepts parallel words through a load/ready handshake and buffers them in a small FIFO.
- Emits the words one bit per clock on the serial line x, which drives the detector's x input directly.
- When no data is pending, drives a constant idle level so the detector never sees spurious zeros.

Parameters:
WIDTH, 8, bits per parallel word
DEPTH, 4, FIFO entries; power of two, minimum 2
MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first
IDLE_BIT, 1, level driven on x when no word is being shifted

Ports:
clk  input  1  single clock; all state changes on its rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
data_in  input  WIDTH  parallel word to enqueue
load  input  1  enqueue request; sampled at posedge clk
ready  output  1  FIFO can accept a word (count < DEPTH)
x  output  1  serial bit to detector; registered
x_valid  output  1  x carries a data bit (not idle); registered
busy  output  1  shifter is in SHIFT state
count  output  $clog2(DEPTH)+1  FIFO occupancy, excludes the word in the shifter

Behaviour:
- Reset (reset==0, asynchronous, takes effect immediately):
  - FIFO empty, pointers 0, count=0, ready=1.
  - Shifter state IDLE, shift register 0, bit index 0.
  - x=IDLE_BIT, x_valid=0, busy=0.
  - A partially sent word is discarded.
- Enqueue: at posedge, if load && ready, write data_in at the write pointer; pointer increments modulo DEPTH. If load && !ready, the request is ignored and nothing changes.
- ready is derived from the registered count: ready = (count < DEPTH). A push is refused while full, even if a pop occurs on the same edge.
- Simultaneous push and pop (not full): both happen and count is unchanged. Pointers wrap modulo DEPTH.
- Shifter FSM, two states:
  - IDLE: x=IDLE_BIT, x_valid=0. At posedge, if count>0, pop the head into the shift register, set index 0, and go to SHIFT.
  - SHIFT: x = current bit (MSB- or LSB-first per MSB_FIRST), x_valid=1. Each posedge advances the index.
  - At the edge ending bit index WIDTH-1: if count>0, pop the next word immediately with no gap cycle; otherwise go to IDLE and x returns to IDLE_BIT.
- No bypass path. A word pushed into an empty FIFO at edge N is popped at edge N+1. Its first bit is on x from edge N+1 to edge N+2.
- Each word occupies exactly WIDTH consecutive x_valid cycles.
- Output timing: x, x_valid and busy are registered and change only on posedge clk or reset.
- busy=1 exactly while in SHIFT. Words are emitted in push order.

Test Plan:
1. Reset, then push 8'h0F once (MSB_FIRST=1) -> starting one cycle after the push edge, x = 0,0,0,0,1,1,1,1 with x_valid=1 for 8 cycles. Then x=1, x_valid=0, busy=0. A downstream detector sees exactly one "000" run.
2. Push 8'h80 and 8'h01 on consecutive edges -> 16 contiguous valid bits 1000000000000001 with no idle cycle between words. count returns to 0.
3. Starting empty, push A,B,C,D,E,F on six consecutive edges -> A is popped at the second edge. After E, count=4 and ready=0. F is refused. Output is exactly A..E, then idle.
4. Push 8'hAA, then assert reset after 3 data bits -> x=1, x_valid=0, busy=0, count=0, ready=1 immediately, before the next edge. After release, x stays idle with no further bits.
5. Push 10 distinct words, pacing pushes only while ready=1 -> all 80 bits emitted in push order. Pointer wrap-around is verified twice.
6. MSB_FIRST=0, push 8'h01 -> x = 1,0,0,0,0,0,0,0, then idle 1.
